// File: rtl/mult_final_add.sv
`default_nettype none
// ============================================================================
// mult_final_add : two-stage carry-propagate adder resolving CSA sum/carry
//                  vectors (low half, then high half). Optional FINAL_ADD_OVF_EN.
// Revision       : 1.0
// ============================================================================
module mult_final_add #(
  parameter int W  = 16,
  parameter int LO = W / 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product
`ifdef FINAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int HI = W - LO;

  logic          s1_valid_q;
  logic          s2_valid_q;
  logic          s2_free;
  logic          s1_adv;
  logic          in_acc;

  logic [LO:0]   lo_sum_d;
  logic [LO-1:0] s1_lo_q;
  logic          s1_c1_q;
  logic [HI-1:0] s1_sh_q;
  logic [HI-1:0] s1_ch_q;

  logic [HI:0]   hi_sum_d;
  logic [W-1:0]  s2_prod_q;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_acc   = in_valid && in_ready;

  // The carry vector is pre-shifted by one; its top bit falls outside W.
  assign lo_sum_d = {1'b0, sum_in[LO-1:0]} + {1'b0, carry_in[LO-2:0], 1'b0};
  assign hi_sum_d = {1'b0, s1_sh_q} + {1'b0, s1_ch_q} + {{HI{1'b0}}, s1_c1_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (in_acc)
        s1_valid_q <= 1'b1;
      else if (s1_adv)
        s1_valid_q <= 1'b0;
      if (s1_adv)
        s2_valid_q <= 1'b1;
      else if (out_ready)
        s2_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lo_q <= '0;
      s1_c1_q <= 1'b0;
      s1_sh_q <= '0;
      s1_ch_q <= '0;
    end else if (in_acc) begin
      s1_lo_q <= lo_sum_d[LO-1:0];
      s1_c1_q <= lo_sum_d[LO];
      s1_sh_q <= sum_in[W-1:LO];
      s1_ch_q <= carry_in[W-2:LO-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s2_prod_q <= '0;
    else if (s1_adv)
      s2_prod_q <= {hi_sum_d[HI-1:0], s1_lo_q};
  end

  assign out_valid = s2_valid_q;
  assign product   = s2_prod_q;

`ifdef FINAL_ADD_OVF_EN
  logic s1_cmsb_q;
  logic s2_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s1_cmsb_q <= 1'b0;
    else if (in_acc)
      s1_cmsb_q <= carry_in[W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s2_ovf_q <= 1'b0;
    else if (s1_adv)
      s2_ovf_q <= hi_sum_d[HI] | s1_cmsb_q;
  end

  assign ovf = s2_ovf_q;
`else
  logic unused_carry_msb;
  assign unused_carry_msb = carry_in[W-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_final_add.sv
`default_nettype none
// Testbench for mult_final_add: vector table, handshake corner sequences and
// randomized streaming against an arithmetic reference model.
module tb_mult_final_add;

  localparam int W = 16;
  localparam int N_RND = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum_in = '0;
  logic [W-1:0] carry_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] product;
`ifdef FINAL_ADD_OVF_EN
  logic         ovf;
`endif

  mult_final_add #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
`ifdef FINAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic; bit 16 reports whether the true sum reached 2^16.
  function automatic logic [16:0] ref_add(input logic [15:0] s, input logic [15:0] c);
    logic [31:0] t;
    t = 32'(s) + 32'(c) * 32'd2;
    return {(t >= 32'h10000), t[15:0]};
  endfunction

  typedef struct {
    logic [15:0] s;
    logic [15:0] c;
    logic [15:0] p;
    logic        ov;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [16:0] q[$];
    logic [16:0] r;
    int acc, got, cyc, sent;

    tbl[0] = '{16'h00FF, 16'h0001, 16'h0101, 1'b0};
    tbl[1] = '{16'h00FF, 16'h0000, 16'h00FF, 1'b0};
    tbl[2] = '{16'h0080, 16'h0040, 16'h0100, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0001, 16'h0001, 1'b1};
    tbl[4] = '{16'h0000, 16'h8000, 16'h0000, 1'b1};
    tbl[5] = '{16'hAAAA, 16'h5555, 16'h5554, 1'b1};
    tbl[6] = '{16'h7F80, 16'h0040, 16'h8000, 1'b0};
    tbl[7] = '{16'h1234, 16'h0101, 16'h1436, 1'b0};
    tbl[8] = '{16'h0001, 16'h7FFF, 16'hFFFF, 1'b0};

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FINAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    #3 rst_n = 1'b1;
    step();

    // Single transfers from the vector table
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      sum_in   = tbl[i].s;
      carry_in = tbl[i].c;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_lat1_valid", i), 32'(out_valid), 32'd0);
      step();
      chk($sformatf("tbl%0d_lat2_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_product", i), 32'(product), 32'(tbl[i].p));
`ifdef FINAL_ADD_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ov));
`endif
      step();
      chk($sformatf("tbl%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back low-to-high carry crossing
    in_valid = 1'b1; sum_in = 16'h00FF; carry_in = 16'h0000;
    step();
    sum_in = 16'h0080; carry_in = 16'h0040;
    step();
    in_valid = 1'b0;
    chk("x_valid0", 32'(out_valid), 32'd1);
    chk("x_prod0", 32'(product), 32'h00FF);
    step();
    chk("x_valid1", 32'(out_valid), 32'd1);
    chk("x_prod1", 32'(product), 32'h0100);
    step();
    chk("x_drained", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for the first 5 cycles
    acc = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      in_valid  = (acc < 4);
      sum_in    = 16'(acc + 1);
      carry_in  = 16'h0000;
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (acc == 2 && !out_ready)
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (out_valid && !out_ready)
        chk("bp_hold", 32'(product), 32'h0001);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d", got), 32'(product), 32'(got + 1));
        got++;
      end
      if (in_valid && in_ready)
        acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_emitted", 32'(got), 32'd4);
    @(negedge clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);
    step();

    // Asynchronous reset with two results in flight
    out_ready = 1'b0;
    in_valid = 1'b1; sum_in = 16'h0011; carry_in = 16'h0000;
    step();
    sum_in = 16'h0022;
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_product", 32'(product), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
`ifdef FINAL_ADD_OVF_EN
    chk("ar_ovf", 32'(ovf), 32'd0);
`endif
    step();
    step();
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("ar_silent%0d", i), 32'(out_valid), 32'd0);
    end
    step();

    // Randomized streaming with random backpressure
    sent = 0; cyc = 0;
    while ((sent < N_RND || q.size() > 0) && cyc < 60000) begin
      in_valid  = (sent < N_RND) && ($urandom_range(0, 3) != 0);
      sum_in    = 16'($urandom);
      carry_in  = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_ready)
        chk("rnd_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 32'(out_valid), 32'd0);
        end else begin
          chk("rnd_product", 32'(product), 32'(q[0][15:0]));
`ifdef FINAL_ADD_OVF_EN
          chk("rnd_ovf", 32'(ovf), 32'(q[0][16]));
`endif
          if (out_ready)
            void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        r = ref_add(sum_in, carry_in);
        q.push_back(r);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_sent", 32'(sent), 32'(N_RND));
    chk("rnd_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
